// File: rtl/lsu_bac.sv
// rtl/lsu_bac.sv - byte address converter / load-store unit with read-modify-write for sub-word stores
module lsu_bac #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);
  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_DONE, S_ERR} state_t;

  state_t            state, state_nxt;
  logic              busy_nxt, done_nxt, err_nxt, mem_req_nxt, mem_we_nxt;
  logic [DATA_W-1:0] rdata_nxt, mem_wdata_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;

  // Request fields captured at accept; the CPU side may change them while busy.
  logic              we_q, we_nxt;
  logic [1:0]        size_q, size_nxt;
  logic              sign_q, sign_nxt;
  logic [LANE_W-1:0] lane_q, lane_nxt;
  logic [DATA_W-1:0] wdata_q, wdata_nxt;

  logic [2:0]        align_mask;
  logic [3:0]        req_bytes;
  logic              size_bad, misaligned, full_word;

  logic [LANE_W+2:0] lane_bits;
  logic [DATA_W-1:0] byte_mask, shifted, load_val, merged;
  logic              sign_bit;

  // Decode the incoming request: legality, alignment and whether it covers a whole word.
  always_comb begin
    case (size)
      2'd0:    align_mask = 3'b000;
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
    req_bytes  = 4'd1 << size;
    size_bad   = (req_bytes > 4'(NB));
    misaligned = |(addr[2:0] & align_mask);
    full_word  = (req_bytes == 4'(NB));
  end

  // Lane datapath: load extraction/extension and sub-word merge into the old memory word.
  always_comb begin
    lane_bits = {lane_q, 3'b000};
    // Shifting by the full word width yields zero, so a full-width access gets an all-ones mask.
    byte_mask = ~({DATA_W{1'b1}} << (7'd8 << size_q));
    shifted   = mem_rdata >> lane_bits;
    case (size_q)
      2'd0:    sign_bit = shifted[7];
      2'd1:    sign_bit = shifted[15];
      2'd2:    sign_bit = shifted[31];
      default: sign_bit = shifted[DATA_W-1];
    endcase
    load_val = (shifted & byte_mask) | ((sign_q && sign_bit) ? ~byte_mask : '0);
    merged   = (mem_rdata & ~(byte_mask << lane_bits)) | ((wdata_q & byte_mask) << lane_bits);
  end

  // State and all registered outputs; reset aborts any access, including mid-RMW.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      we_q      <= 1'b0;
      size_q    <= 2'd0;
      sign_q    <= 1'b0;
      lane_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state     <= state_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      rdata     <= rdata_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      we_q      <= we_nxt;
      size_q    <= size_nxt;
      sign_q    <= sign_nxt;
      lane_q    <= lane_nxt;
      wdata_q   <= wdata_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;
    rdata_nxt     = rdata;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    we_nxt        = we_q;
    size_nxt      = size_q;
    sign_nxt      = sign_q;
    lane_nxt      = lane_q;
    wdata_nxt     = wdata_q;

    case (state)
      S_IDLE: begin
        busy_nxt = 1'b0;
        if (req) begin
          busy_nxt  = 1'b1;
          we_nxt    = we;
          size_nxt  = size;
          sign_nxt  = sign_ext;
          lane_nxt  = addr[LANE_W-1:0];
          wdata_nxt = wdata;
          if (size_bad || misaligned) begin
            state_nxt = S_ERR;
            done_nxt  = 1'b1;
            err_nxt   = 1'b1;
          end else begin
            mem_addr_nxt = {addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
            mem_req_nxt  = 1'b1;
            if (we && full_word) begin
              state_nxt     = S_WR;
              mem_we_nxt    = 1'b1;
              mem_wdata_nxt = wdata;
            end else begin
              // Loads and sub-word stores both start by reading the whole word.
              state_nxt  = S_RD;
              mem_we_nxt = 1'b0;
            end
          end
        end
      end

      S_RD: begin
        if (mem_req && mem_ack) begin
          mem_req_nxt = 1'b0;
          if (we_q) begin
            // Merged word waits one idle memory cycle before the write phase starts.
            state_nxt     = S_WR;
            mem_wdata_nxt = merged;
          end else begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
            rdata_nxt = load_val;
          end
        end
      end

      S_WR: begin
        if (!mem_req) begin
          mem_req_nxt = 1'b1;
          mem_we_nxt  = 1'b1;
        end else if (mem_ack) begin
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
          state_nxt   = S_DONE;
          done_nxt    = 1'b1;
        end
      end

      S_DONE, S_ERR: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
      end

      default: begin
        state_nxt   = S_IDLE;
        busy_nxt    = 1'b0;
        mem_req_nxt = 1'b0;
        mem_we_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_lsu_bac.sv
// tb/tb_lsu_bac.sv - table-driven scoreboard bench for lsu_bac at DATA_W=32 and DATA_W=64
module tb_lsu_bac;
  typedef struct {
    bit          sel;
    bit          we;
    logic [1:0]  size;
    bit          sext;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] old;
    int          waits;
    bit          exp_err;
    logic [63:0] exp_rdata;
    logic [31:0] exp_maddr;
    logic [63:0] exp_wdata;
    int          exp_nrd;
    int          exp_nwr;
    int          exp_lat;
    bit          poke;
  } vec_t;

  typedef struct {
    bit          err;
    logic [63:0] rdata;
    int          lat;
    int          nrd;
    int          nwr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, req, sel, we, sign_ext, mem_ack;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [63:0] wdata, mem_rdata;

  logic        busy32, done32, err32, mem_req32, mem_we32;
  logic [31:0] rdata32, mem_addr32, mem_wdata32;
  logic        busy64, done64, err64, mem_req64, mem_we64;
  logic [63:0] rdata64, mem_wdata64;
  logic [31:0] mem_addr64;

  logic        r_busy, r_done, r_err, r_mem_req, r_mem_we;
  logic [63:0] r_rdata, r_mem_wdata;
  logic [31:0] r_mem_addr;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  lsu_bac #(.DATA_W(32), .ADDR_W(32)) dut32 (
    .clk(clk), .rst(rst), .req(req && !sel), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata[31:0]), .busy(busy32), .done(done32), .err(err32),
    .rdata(rdata32), .mem_req(mem_req32), .mem_we(mem_we32), .mem_addr(mem_addr32),
    .mem_wdata(mem_wdata32), .mem_rdata(mem_rdata[31:0]), .mem_ack(mem_ack && !sel)
  );

  lsu_bac #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst(rst), .req(req && sel), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .busy(busy64), .done(done64), .err(err64),
    .rdata(rdata64), .mem_req(mem_req64), .mem_we(mem_we64), .mem_addr(mem_addr64),
    .mem_wdata(mem_wdata64), .mem_rdata(mem_rdata), .mem_ack(mem_ack && sel)
  );

  assign r_busy      = sel ? busy64 : busy32;
  assign r_done      = sel ? done64 : done32;
  assign r_err       = sel ? err64 : err32;
  assign r_mem_req   = sel ? mem_req64 : mem_req32;
  assign r_mem_we    = sel ? mem_we64 : mem_we32;
  assign r_mem_addr  = sel ? mem_addr64 : mem_addr32;
  assign r_rdata     = sel ? rdata64 : {32'b0, rdata32};
  assign r_mem_wdata = sel ? mem_wdata64 : {32'b0, mem_wdata32};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_access(input vec_t v);
    exp_t e;
    int   cyc, nrd, nwr, wcnt, gap;
    bit   in_phase, phase_we, seen_done;
    cyc = 0; nrd = 0; nwr = 0; wcnt = 0; gap = 0;
    in_phase = 0; phase_we = 0; seen_done = 0;
    @(negedge clk);
    sel = v.sel; req = 1'b1; we = v.we; size = v.size; sign_ext = v.sext;
    addr = v.addr; wdata = v.wdata;
    sb.push_back('{v.exp_err, v.exp_rdata, v.exp_lat, v.exp_nrd, v.exp_nwr});
    @(negedge clk);
    cyc = 1;
    // Scramble the CPU-side inputs so only latched values can produce the right answer.
    we = ~v.we; sign_ext = ~v.sext; size = 2'($urandom_range(0, 3));
    addr = $urandom; wdata = {$urandom, $urandom};
    while (!seen_done && cyc < 64) begin
      req = v.poke && (cyc == 2);
      if (r_mem_req) begin
        if (!in_phase) begin
          in_phase = 1; phase_we = r_mem_we; wcnt = 0;
          if (r_mem_we) nwr++; else nrd++;
        end
        check("mem_addr", r_mem_addr, v.exp_maddr);
        check("mem_we_stable", r_mem_we, phase_we);
        if (r_mem_we) check("mem_wdata", r_mem_wdata, v.exp_wdata);
        mem_ack   = (wcnt == v.waits);
        mem_rdata = (wcnt == v.waits) ? v.old : {$urandom, $urandom};
        wcnt++;
      end else begin
        in_phase = 0; mem_ack = 1'b0; mem_rdata = {$urandom, $urandom};
        if (v.exp_nrd == 1 && v.exp_nwr == 1 && nrd + nwr == 1) gap++;
      end
      if (r_done) begin
        seen_done = 1;
        e = sb.pop_front();
        check("err", r_err, e.err);
        check("rdata", r_rdata, e.rdata);
        check("latency", cyc, e.lat);
        check("busy_at_done", r_busy, 1);
        check("reads", nrd, e.nrd);
        check("writes", nwr, e.nwr);
        if (e.nrd == 1 && e.nwr == 1) check("rmw_gap", gap, 1);
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen_done) begin
      n_vec++; n_bad++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected latency %0d", cyc, v.exp_lat);
      sb.delete();
    end
    mem_ack = 1'b0; req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_busy", r_busy, 0);
      check("idle_done", r_done, 0);
      check("idle_mem_req", r_mem_req, 0);
    end
  endtask

  initial begin
    rst = 1'b0; req = 1'b0; sel = 1'b0; we = 1'b0; size = 2'd0; sign_ext = 1'b0;
    addr = '0; wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctl32", {busy32, done32, err32, mem_req32, mem_we32}, 0);
    check("rst_rdata32", rdata32, 0);
    check("rst_maddr32", mem_addr32, 0);
    check("rst_mwdata32", mem_wdata32, 0);
    check("rst_ctl64", {busy64, done64, err64, mem_req64, mem_we64}, 0);
    check("rst_rdata64", rdata64, 0);
    check("rst_maddr64", mem_addr64, 0);
    check("rst_mwdata64", mem_wdata64, 0);
    rst = 1'b1;

    //            sel we sz sx addr      wdata                  old                    w  er rdata                   maddr   mem_wdata              rd wr lat poke
    tbl.push_back('{0, 0, 0, 1, 'h1003, 'h0,                  'h80112233,            0, 0, 'hFFFFFF80,            'h1000, 'h0,                  1, 0, 2, 0});
    tbl.push_back('{0, 0, 0, 0, 'h1003, 'h0,                  'h80112233,            0, 0, 'h00000080,            'h1000, 'h0,                  1, 0, 2, 0});
    tbl.push_back('{0, 1, 1, 0, 'h2002, 'hBEEF,               'h11223344,            0, 0, 'h00000080,            'h2000, 'hBEEF3344,           1, 1, 4, 0});
    tbl.push_back('{0, 1, 2, 0, 'h2001, 'h12345678,           'h0,                   0, 1, 'h00000080,            'h0,    'h0,                  0, 0, 1, 0});
    tbl.push_back('{0, 0, 1, 1, 'h3003, 'h0,                  'h0,                   0, 1, 'h00000080,            'h0,    'h0,                  0, 0, 1, 0});
    tbl.push_back('{0, 0, 2, 0, 'h4000, 'h0,                  'hCAFEF00D,            3, 0, 'hCAFEF00D,            'h4000, 'h0,                  1, 0, 5, 1});
    tbl.push_back('{0, 0, 1, 1, 'h1002, 'h0,                  'h80112233,            0, 0, 'hFFFF8011,            'h1000, 'h0,                  1, 0, 2, 0});
    tbl.push_back('{0, 0, 0, 1, 'h1001, 'h0,                  'h80112233,            1, 0, 'h00000022,            'h1000, 'h0,                  1, 0, 3, 0});
    tbl.push_back('{0, 1, 0, 0, 'h5001, 'hFFFFFFA5,           'h11223344,            1, 0, 'h00000022,            'h5000, 'h1122A544,           1, 1, 6, 0});
    tbl.push_back('{0, 1, 3, 0, 'h0008, 'h1,                  'h0,                   0, 1, 'h00000022,            'h0,    'h0,                  0, 0, 1, 0});
    tbl.push_back('{0, 1, 2, 0, 'h6000, 'h12345678,           'hDEADDEAD,            0, 0, 'h00000022,            'h6000, 'h12345678,           0, 1, 2, 0});
    tbl.push_back('{0, 0, 1, 1, 'h1000, 'h0,                  'h0000F00D,            0, 0, 'hFFFFF00D,            'h1000, 'h0,                  1, 0, 2, 0});
    tbl.push_back('{1, 0, 1, 1, 'h0006, 'h0,                  'h8001000000000000,    0, 0, 'hFFFFFFFFFFFF8001,    'h0,    'h0,                  1, 0, 2, 0});
    tbl.push_back('{1, 1, 3, 0, 'h0008, 'h0123456789ABCDEF,   'h0,                   0, 0, 'hFFFFFFFFFFFF8001,    'h8,    'h0123456789ABCDEF,   0, 1, 2, 0});
    tbl.push_back('{1, 1, 2, 0, 'h000C, 'hDEADBEEF,           'h1111111122222222,    0, 0, 'hFFFFFFFFFFFF8001,    'h8,    'hDEADBEEF22222222,   1, 1, 4, 0});
    tbl.push_back('{1, 0, 2, 1, 'h0004, 'h0,                  'h8000000012345678,    0, 0, 'hFFFFFFFF80000000,    'h0,    'h0,                  1, 0, 2, 0});
    tbl.push_back('{1, 0, 3, 0, 'h0004, 'h0,                  'h0,                   0, 1, 'hFFFFFFFF80000000,    'h0,    'h0,                  0, 0, 1, 0});

    foreach (tbl[i]) run_access(tbl[i]);

    // Reset in the write phase of a sub-word store, then a late ack.
    @(negedge clk);
    sel = 1'b0; req = 1'b1; we = 1'b1; size = 2'd0; sign_ext = 1'b0; addr = 32'h5002; wdata = 64'h77;
    @(negedge clk);
    req = 1'b0;
    check("rmw_rd_phase", {r_mem_req, r_mem_we}, 2'b10);
    mem_ack = 1'b1; mem_rdata = 64'hAABBCCDD;
    @(negedge clk);
    mem_ack = 1'b0;
    check("rmw_gap_req", r_mem_req, 0);
    @(negedge clk);
    check("rmw_wr_phase", {r_mem_req, r_mem_we}, 2'b11);
    check("rmw_wr_data", r_mem_wdata, 64'hAA77CCDD);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("abort_ctl", {r_busy, r_done, r_err, r_mem_req, r_mem_we}, 0);
    check("abort_rdata", r_rdata, 0);
    check("abort_maddr", r_mem_addr, 0);
    check("abort_mwdata", r_mem_wdata, 0);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("late_ack_done", r_done, 0);
      check("late_ack_busy", r_busy, 0);
      check("late_ack_mem_req", r_mem_req, 0);
      @(negedge clk);
    end

    run_access('{0, 0, 0, 0, 'h1003, 'h0,    'h80112233, 0, 0, 'h00000080, 'h1000, 'h0,        1, 0, 2, 0});
    run_access('{0, 1, 1, 0, 'h2000, 'h1234, 'hAAAA5555, 0, 0, 'h00000080, 'h2000, 'hAAAA1234, 1, 1, 4, 0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, expected finish");
    $fatal(1);
  end
endmodule

// File: doc/lsu_bac.md
Name: lsu_bac

Overview:
Multi-cycle, parametrised byte address converter / load-store unit between the MEM stage and a word-organised data memory with a single request/ack port. Supports byte, halfword and word (doubleword when DATA_W=64) accesses, signed/unsigned load extension, alignment checking, and read-modify-write for sub-word stores. Memory never receives byte enables: every sub-word store is a full-word read followed by a merged full-word write.

Parameters:
DATA_W, 32, memory word width in bits; power of two, 32 or 64
ADDR_W, 32, byte-address width
LANE_W, log2(DATA_W/8), number of byte-offset bits inside a word (derived, not overridable)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-low
req  in  1  CPU access request, sampled only when busy=0
we  in  1  1=store, 0=load
size  in  2  access size = 2^size bytes (0 byte, 1 half, 2 word, 3 dword)
sign_ext  in  1  load only: 1 sign-extend, 0 zero-extend
addr  in  ADDR_W  byte address
wdata  in  DATA_W  store data, right-justified in low bits
busy  out  1  1 while an access is in progress
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse with done on rejected access
rdata  out  DATA_W  extended load result, valid while done=1, held until next load done
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write strobe, qualified by mem_req
mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:LANE_W], LANE_W'b0}
mem_wdata  out  DATA_W  full-word write data
mem_rdata  in  DATA_W  full-word read data, valid with mem_ack on a read
mem_ack  in  1  memory completion, sampled only while mem_req=1

Behaviour:
- States: IDLE, RD, WR, DONE, ERR. All outputs are registered.
- Reset (rst=0 at a clock edge): state IDLE; busy, done, err, mem_req and mem_we = 0; rdata, mem_addr and mem_wdata = 0. This applies in any state, including mid-RMW. Any later mem_ack for the aborted access is ignored.
- IDLE with req=1 latches we, size, sign_ext, addr and wdata, and sets busy=1 on the next edge. A req while busy=1 is ignored, not queued.
- Misalignment or illegal size moves IDLE -> ERR, with no memory transaction. Misaligned means addr[size-1:0] != 0. Illegal size means 2^size > DATA_W/8.
- ERR lasts one cycle with done=1, err=1, rdata unchanged, then returns to IDLE with busy=0.
- Load: IDLE -> RD, where mem_req=1 and mem_we=0.
  - On the edge where mem_ack=1, compute lane = addr[LANE_W-1:0] and shifted = mem_rdata >> (lane*8).
  - Keep the low 2^size bytes of shifted; extend with its MSB if sign_ext=1, else with zeros. Capture the result into rdata.
  - Then RD -> DONE.
- Full-word store (2^size = DATA_W/8): IDLE -> WR, with mem_req=1, mem_we=1 and mem_wdata = wdata.
- Sub-word store: IDLE -> RD to read the old word. On mem_ack, merge: the 2^size bytes starting at byte lane `lane` are replaced by the low bytes of wdata; all other bytes keep their old value. Then RD -> WR with the merged word. sign_ext is ignored for stores.
- WR with mem_ack=1 -> DONE.
- DONE lasts one cycle with done=1 and err=0, then IDLE; busy falls on the same edge.
- mem_req deasserts on the edge after mem_ack. Between RD and WR of an RMW, mem_req falls for exactly one cycle.
- mem_addr, mem_we and mem_wdata stay stable while mem_req=1.
- mem_ack is ignored when mem_req=0.
- Latency with a zero-wait memory (ack in the first mem_req cycle):
  - load: done at accept+2
  - word store: done at accept+2
  - sub-word store: done at accept+4
- Each extra wait cycle adds one cycle per memory phase.
- rdata is not modified by stores or errors.

Test Plan:
- Load byte, DATA_W=32, addr=0x1003, mem_rdata=0x80112233, sign_ext=1: one read at mem_addr=0x1000; rdata=0xFFFFFF80, done at accept+2. Repeat with sign_ext=0: rdata=0x00000080.
- Store half 0xBEEF at addr=0x2002, old word 0x11223344: read 0x2000, then write mem_wdata=0xBEEF3344; mem_req low for exactly one cycle between the phases; done at accept+4.
- Store word addr=0x2001, and load half addr=0x3003: each gives done=err=1 for one cycle, mem_req never asserts, rdata unchanged.
- Word load with mem_ack delayed 3 cycles: mem_req, mem_addr and mem_we stay stable; done exactly 1 cycle after the ack edge. A second req while busy is ignored.
- rst=0 while in WR of an RMW: next edge gives all outputs 0 and IDLE state; a late mem_ack produces no done. A new req after reset completes normally.
- DATA_W=64, load half addr=0x0006, mem_rdata=0x8001_0000_0000_0000, sign_ext=1: rdata=0xFFFF_FFFF_FFFF_8001. size=3 with addr=0x8 stores the full word directly (no RMW).
